reset_sequencer: RTL and testbench

Multi-domain reset sequencer that sits directly downstream of the power-on reset stretcher. Its synchronous active-low reset is the inverted stretcher output. It qualifies PLL lock, then releases up to STAGES reset domains in fixed order (stage 0 first, e.g. memory controller; last stage, e.g. peripherals), one every DELAY cycles. It also services software-requested warm resets that keep stage 0 running.

---
 rtl/reset_sequencer_if.sv | 36 +++
 rtl/reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_reset_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// ============================================================================
//  Module      : reset_sequencer_if
//  Description : Lock/request inputs and reset/ready/ack outputs of the
//                multi-domain reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              i_pll_locked;
    logic              i_sw_reset_request;
    logic              o_sw_reset_ack;
    logic [STAGES-1:0] o_stage_reset;
    logic              o_ready;

    // Master drives lock/request and observes the sequencer outputs.
    modport master (
        output i_pll_locked,
        output i_sw_reset_request,
        input  o_sw_reset_ack,
        input  o_stage_reset,
        input  o_ready
    );

    modport slave (
        input  i_pll_locked,
        input  i_sw_reset_request,
        output o_sw_reset_ack,
        output o_stage_reset,
        output o_ready
    );
endinterface

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
//  Module      : reset_sequencer
//  Description : Qualifies PLL lock, releases reset domains in ascending
//                order and services warm resets that keep stage 0 running.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer #(
    parameter int STAGES   = 3,
    parameter int DELAY    = 16,
    parameter int REQ_HOLD = 8
) (
    input  wire logic         i_clock,
    input  wire logic         i_reset_n,
    reset_sequencer_if.slave  bus
);

    localparam int C_MAX = (DELAY > REQ_HOLD) ? DELAY : REQ_HOLD;
    localparam int CW    = $clog2(C_MAX + 1);
    localparam int IW    = $clog2(STAGES);

    localparam logic [CW-1:0] C_DELAY = CW'(DELAY);
    localparam logic [CW-1:0] C_HOLD  = CW'(REQ_HOLD);
    localparam logic [IW-1:0] C_LAST  = IW'(STAGES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_RELEASE   = 2'd1,
        S_RUN       = 2'd2,
        S_SOFT      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic [STAGES-1:0] stage_q, stage_d;
    logic              ready_q, ready_d;
    logic              ack_q,   ack_d;
    logic              cnt_last;

    // Expiry is the edge on which the counter would reach zero.
    assign cnt_last = (cnt_q <= CW'(1));

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= C_DELAY;
            idx_q   <= '0;
            stage_q <= '1;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        ready_d = ready_q;
        ack_d   = 1'b0;

        if (state_q == S_WAIT_LOCK) begin
            if (!bus.i_pll_locked) begin
                cnt_d = C_DELAY;
            end else if (cnt_last) begin
                stage_d[0] = 1'b0;
                idx_d      = IW'(1);
                cnt_d      = C_DELAY;
                state_d    = S_RELEASE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (!bus.i_pll_locked) begin
            // Lock loss outranks any pending request.
            stage_d = '1;
            ready_d = 1'b0;
            cnt_d   = C_DELAY;
            idx_d   = '0;
            state_d = S_WAIT_LOCK;
        end else begin
            case (state_q)
                S_RELEASE: begin
                    if (cnt_last) begin
                        stage_d = stage_q & ~(STAGES'(1) << idx_q);
                        cnt_d   = C_DELAY;
                        if (idx_q == C_LAST) begin
                            ready_d = 1'b1;
                            state_d = S_RUN;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_RUN: begin
                    stage_d = '0;
                    ready_d = 1'b1;
                    if (bus.i_sw_reset_request) begin
                        stage_d = {{(STAGES-1){1'b1}}, 1'b0};
                        ready_d = 1'b0;
                        ack_d   = 1'b1;
                        cnt_d   = C_HOLD;
                        state_d = S_SOFT;
                    end
                end
                S_SOFT: begin
                    if (cnt_last) begin
                        stage_d[1] = 1'b0;
                        if (STAGES == 2) begin
                            ready_d = 1'b1;
                            state_d = S_RUN;
                        end else begin
                            idx_d   = IW'(2);
                            cnt_d   = C_DELAY;
                            state_d = S_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                end
            endcase
        end
    end

    assign bus.o_stage_reset  = stage_q;
    assign bus.o_ready        = ready_q;
    assign bus.o_sw_reset_ack = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Scoreboard bench driving a default and a small-parameter
//                sequencer from shared stimulus against a timing model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    localparam int SA = 3, DA = 16, HA = 8;
    localparam int SB = 2, DB = 4,  HB = 2;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;

    reset_sequencer_if #(.STAGES(SA)) bus_a ();
    reset_sequencer_if #(.STAGES(SB)) bus_b ();

    reset_sequencer #(.STAGES(SA), .DELAY(DA), .REQ_HOLD(HA)) u_dut_a (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus_a.slave)
    );

    reset_sequencer #(.STAGES(SB), .DELAY(DB), .REQ_HOLD(HB)) u_dut_b (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase kind plus edges elapsed since the phase began.
    typedef struct {
        logic warm;
        int   t;
        logic ack;
    } mdl_t;

    typedef struct {
        logic [7:0] ba;
        logic       ra;
        logic       aa;
        logic [7:0] bb;
        logic       rb;
        logic       ab;
    } exp_t;

    exp_t q[$];
    mdl_t ma, mb;

    function automatic logic [7:0] exp_bits(input int s, input int d, input int h, input mdl_t m);
        logic [7:0] b;
        logic       rel;
        b = '0;
        for (int k = 0; k < s; k++) begin
            if (m.warm) begin
                if (k == 0)      rel = 1'b1;
                else if (k == 1) rel = (m.t >= h);
                else             rel = (m.t >= h + (k - 1) * d);
            end else begin
                rel = (m.t >= (k + 1) * d);
            end
            b[k] = !rel;
        end
        return b;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int s, input int d, input int h,
                                  input logic rn, input logic lk, input logic rq);
        mdl_t n;
        n     = m;
        n.ack = 1'b0;
        if (!rn || !lk) begin
            n.warm = 1'b0;
            n.t    = 0;
        end else if (exp_bits(s, d, h, m) == 8'd0) begin
            if (rq) begin
                n.warm = 1'b1;
                n.t    = 0;
                n.ack  = 1'b1;
            end
        end else begin
            n.t = m.t + 1;
        end
        return n;
    endfunction

    task automatic drive(input logic rn, input logic lk, input logic rq, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rst_n                    = rn;
            bus_a.i_pll_locked       = lk;
            bus_a.i_sw_reset_request = rq;
            bus_b.i_pll_locked       = lk;
            bus_b.i_sw_reset_request = rq;
            ma   = step(ma, SA, DA, HA, rn, lk, rq);
            mb   = step(mb, SB, DB, HB, rn, lk, rq);
            e.ba = exp_bits(SA, DA, HA, ma);
            e.ra = (e.ba == 8'd0);
            e.aa = ma.ack;
            e.bb = exp_bits(SB, DB, HB, mb);
            e.rb = (e.bb == 8'd0);
            e.ab = mb.ack;
            q.push_back(e);
            @(negedge clk);
        end
    endtask

    // Monitor: every edge presents a fresh registered output set.
    initial begin
        exp_t e;
        logic [7:0] sa, sb;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() != 0) begin
                e  = q.pop_front();
                sa = 8'(bus_a.o_stage_reset);
                sb = 8'(bus_b.o_stage_reset);
                tests++;
                if (sa !== e.ba || bus_a.o_ready !== e.ra || bus_a.o_sw_reset_ack !== e.aa) begin
                    fails++;
                    $display("FAIL dutA cyc %0d: got stage=%b ready=%b ack=%b, expected stage=%b ready=%b ack=%b",
                             cyc, sa, bus_a.o_ready, bus_a.o_sw_reset_ack, e.ba, e.ra, e.aa);
                end
                tests++;
                if (sb !== e.bb || bus_b.o_ready !== e.rb || bus_b.o_sw_reset_ack !== e.ab) begin
                    fails++;
                    $display("FAIL dutB cyc %0d: got stage=%b ready=%b ack=%b, expected stage=%b ready=%b ack=%b",
                             cyc, sb, bus_b.o_ready, bus_b.o_sw_reset_ack, e.bb, e.rb, e.ab);
                end
            end
        end
    end

    initial begin
        tests   = 0;
        fails   = 0;
        ma.warm = 1'b0; ma.t = 0; ma.ack = 1'b0;
        mb.warm = 1'b0; mb.t = 0; mb.ack = 1'b0;

        // Cold start with lock high throughout, then a warm reset.
        drive(1'b0, 1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 1'b0, 60);
        drive(1'b1, 1'b1, 1'b1, 1);
        drive(1'b1, 1'b1, 1'b0, 30);
        // Request held through the warm reset retriggers on entering RUN.
        drive(1'b1, 1'b1, 1'b1, 40);
        drive(1'b1, 1'b1, 1'b0, 30);
        // Lock glitch at edge 10 of WAIT_LOCK.
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 1'b0, 9);
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b1, 1'b1, 1'b0, 60);
        // Request coinciding with lock loss in RUN.
        drive(1'b1, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b1, 1'b0, 60);
        // Reset pulse in the middle of RELEASE.
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b1, 1'b1, 1'b0, 20);
        drive(1'b0, 1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, 1'b0, 60);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 399) != 0),
                  ($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 7) == 0), 1);
        end

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
